// File: rtl/nibble_sequencer_if.sv
// nibble_sequencer_if
// Purpose: bundles every non-clock/reset signal of the nibble CPU sequencer.
//   slave  modport: the sequencer (takes requests/decoder/ALU/ROM inputs,
//                   drives pc, phase, latches, flags and debug status).
//   master modport: the surrounding system / testbench.
// Signalling: there is no valid/ready handshake on this block. run_req,
// step_req and halt_req are single-cycle request pulses sampled on the rising
// clock edge; the block acknowledges only a completed step (one-cycle
// step_ack) and reflects run state on halted/bp_hit. state_dbg mirrors the
// internal FSM state (0 HALT, 1 FETCH, 2 EXEC) for checkers.
interface nibble_sequencer_if #(
  parameter int PC_W  = 12,
  parameter int CNT_W = 16
);
  logic              run_req;
  logic              step_req;
  logic              halt_req;
  logic              bp_en;
  logic [PC_W-1:0]   bp_addr;
  logic [PC_W+7:0]   prog_word;
  logic              inc_pc;
  logic              load_pc;
  logic              load_flags;
  logic              alu_carry;
  logic              alu_zero;
  logic [PC_W-1:0]   pc;
  logic              phase;
  logic              exec_en;
  logic [3:0]        instr;
  logic [3:0]        oprnd;
  logic              c_flag;
  logic              z_flag;
  logic              halted;
  logic              step_ack;
  logic              bp_hit;
  logic [CNT_W-1:0]  instr_count;
  logic [1:0]        state_dbg;

  modport slave (
    input  run_req, step_req, halt_req, bp_en, bp_addr, prog_word,
           inc_pc, load_pc, load_flags, alu_carry, alu_zero,
    output pc, phase, exec_en, instr, oprnd, c_flag, z_flag,
           halted, step_ack, bp_hit, instr_count, state_dbg
  );

  modport master (
    output run_req, step_req, halt_req, bp_en, bp_addr, prog_word,
           inc_pc, load_pc, load_flags, alu_carry, alu_zero,
    input  pc, phase, exec_en, instr, oprnd, c_flag, z_flag,
           halted, step_ack, bp_hit, instr_count, state_dbg
  );
endinterface

// File: rtl/nibble_sequencer.sv
// nibble_sequencer
// Purpose: run-control and fetch/execute sequencer of the 4-bit nibble CPU.
//   Owns the program counter, the two-phase FETCH/EXEC timing, the
//   opcode/operand/jump-target latches, the C/Z flags and a saturating
//   retired-instruction counter. Provides run / single-step / halt control
//   and a single-address breakpoint.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high reset
//   bus    - nibble_sequencer_if.slave (requests, ROM word, decoder controls,
//            ALU flags in; pc, phase, exec_en, latches, flags, status out)
module nibble_sequencer #(
  parameter int PC_W  = 12,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  nibble_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [PC_W-1:0]   r_pc;
  logic [3:0]        r_instr;
  logic [3:0]        r_oprnd;
  logic [PC_W-1:0]   r_jmp;
  logic              r_c;
  logic              r_z;
  logic              r_step_ack;
  logic              r_bp_hit;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_halt_pend;
  logic              r_step_mode;

  logic [PC_W-1:0]   w_next_pc;
  logic              w_halt_pend;
  logic              w_bp_match;

  // PC value at the end of the current EXEC; load_pc beats inc_pc.
  always_comb begin
    w_next_pc = r_pc;
    if (bus.load_pc)
      w_next_pc = r_jmp;
    else if (bus.inc_pc)
      w_next_pc = r_pc + PC_W'(1);
  end

  // A halt_req arriving in the EXEC cycle itself still stops at the end of
  // that instruction, so it is folded in with the registered pending bit.
  assign w_halt_pend = r_halt_pend | bus.halt_req;
  assign w_bp_match  = bus.bp_en && (w_next_pc == bus.bp_addr);

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= ST_HALT;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_HALT: begin
        if (bus.step_req || bus.run_req)
          w_next_state = ST_FETCH;
      end
      ST_FETCH: w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (r_step_mode || w_halt_pend || w_bp_match)
          w_next_state = ST_HALT;
        else
          w_next_state = ST_FETCH;
      end
      default: w_next_state = ST_HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= '0;
      r_instr     <= '0;
      r_oprnd     <= '0;
      r_jmp       <= '0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
      r_step_ack  <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_cnt       <= '0;
      r_halt_pend <= 1'b0;
      r_step_mode <= 1'b0;
    end else begin
      r_step_ack <= 1'b0;
      case (r_state)
        ST_HALT: begin
          // step_req wins over a simultaneous run_req; halt_req is ignored.
          if (bus.step_req) begin
            r_step_mode <= 1'b1;
            r_bp_hit    <= 1'b0;
          end else if (bus.run_req) begin
            r_step_mode <= 1'b0;
            r_bp_hit    <= 1'b0;
          end
        end
        ST_FETCH: begin
          r_instr <= bus.prog_word[7:4];
          r_oprnd <= bus.prog_word[3:0];
          r_jmp   <= bus.prog_word[PC_W+7:8];
          if (bus.halt_req)
            r_halt_pend <= 1'b1;
        end
        ST_EXEC: begin
          r_pc <= w_next_pc;
          if (bus.load_flags) begin
            r_c <= bus.alu_carry;
            r_z <= bus.alu_zero;
          end
          if (r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + CNT_W'(1);
          // Any return to HALT drops a stale halt request so it cannot
          // cut short the next run.
          if (r_step_mode) begin
            r_step_ack  <= 1'b1;
            r_step_mode <= 1'b0;
            r_halt_pend <= 1'b0;
          end else if (w_halt_pend) begin
            r_halt_pend <= 1'b0;
          end else if (w_bp_match) begin
            r_bp_hit <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc          = r_pc;
  assign bus.phase       = (r_state == ST_EXEC);
  assign bus.exec_en     = (r_state == ST_EXEC);
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.instr       = r_instr;
  assign bus.oprnd       = r_oprnd;
  assign bus.c_flag      = r_c;
  assign bus.z_flag      = r_z;
  assign bus.step_ack    = r_step_ack;
  assign bus.bp_hit      = r_bp_hit;
  assign bus.instr_count = r_cnt;
  assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_nibble_sequencer.sv
// tb_nibble_sequencer
// Purpose: self-checking bench for nibble_sequencer. Each scenario task
// pushes the pc expected after every instruction it retires onto exp_q;
// the tick task pops and compares whenever an EXEC cycle completes.
module tb_nibble_sequencer;
  localparam int PC_W  = 12;
  localparam int CNT_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [PC_W-1:0] rom_tgt = '0;
  logic [3:0]      rom_op  = '0;
  logic [3:0]      rom_opr = '0;
  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [PC_W-1:0] exp_q[$];

  nibble_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  assign bus.prog_word = {rom_tgt, rom_op, rom_opr};

  nibble_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.run_req    = 1'b0;
    bus.step_req   = 1'b0;
    bus.halt_req   = 1'b0;
    bus.bp_en      = 1'b0;
    bus.bp_addr    = '0;
    bus.inc_pc     = 1'b0;
    bus.load_pc    = 1'b0;
    bus.load_flags = 1'b0;
    bus.alu_carry  = 1'b0;
    bus.alu_zero   = 1'b0;
  endtask

  // One clock; inputs change and outputs are sampled 1ns after the edge.
  // If the cycle just finished was EXEC, the new pc is scoreboarded.
  task automatic tick();
    logic was_exec;
    logic [PC_W-1:0] e;
    was_exec = bus.phase;
    @(posedge clock);
    #1;
    if (mon_en && was_exec) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL retire_unexpected pc=%h exp=none", bus.pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.pc !== e) begin
          bad++;
          $display("FAIL retire_pc got=%h exp=%h", bus.pc, e);
        end
      end
    end
  endtask

  task automatic do_step();
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    total++; if (bus.pc !== 12'h000) begin bad++; $display("FAIL reset_pc got=%h exp=000", bus.pc); end
    total++; if (bus.halted !== 1'b1 || bus.phase !== 1'b0 || bus.exec_en !== 1'b0) begin bad++; $display("FAIL reset_state got halted=%b phase=%b exec_en=%b exp 1 0 0", bus.halted, bus.phase, bus.exec_en); end
    total++; if ({bus.instr, bus.oprnd, bus.c_flag, bus.z_flag, bus.step_ack, bus.bp_hit} !== 12'h000) begin bad++; $display("FAIL reset_regs got instr=%h oprnd=%h c=%b z=%b ack=%b bp=%b exp all 0", bus.instr, bus.oprnd, bus.c_flag, bus.z_flag, bus.step_ack, bus.bp_hit); end
    total++; if (bus.instr_count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.instr_count); end
    mon_en = 1'b1;
  endtask

  task automatic test_run_basic();
    rom_tgt = 12'h000; rom_op = 4'h4; rom_opr = 4'h1;
    bus.inc_pc = 1'b1;
    exp_q.push_back(12'h001);
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    total++; if (bus.phase !== 1'b0 || bus.halted !== 1'b0) begin bad++; $display("FAIL run_fetch got phase=%b halted=%b exp 0 0", bus.phase, bus.halted); end
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    total++; if (bus.phase !== 1'b1 || bus.exec_en !== 1'b1) begin bad++; $display("FAIL run_exec got phase=%b exec_en=%b exp 1 1", bus.phase, bus.exec_en); end
    total++; if (bus.instr !== 4'h4 || bus.oprnd !== 4'h1) begin bad++; $display("FAIL run_latch got instr=%h oprnd=%h exp 4 1", bus.instr, bus.oprnd); end
    total++; if (bus.pc !== 12'h000) begin bad++; $display("FAIL run_pc_hold got=%h exp=000", bus.pc); end
    tick();
    total++; if (bus.halted !== 1'b1 || bus.instr_count !== 16'd1) begin bad++; $display("FAIL run_end got halted=%b count=%0d exp 1 1", bus.halted, bus.instr_count); end
  endtask

  task automatic test_jump_wrap();
    rom_tgt = 12'h123;
    bus.load_pc = 1'b1; bus.inc_pc = 1'b1;
    exp_q.push_back(12'h123);
    do_step();
    rom_tgt = 12'hFFF;
    exp_q.push_back(12'hFFF);
    do_step();
    bus.load_pc = 1'b0;
    exp_q.push_back(12'h000);
    do_step();
    total++; if (bus.instr_count !== 16'd4 || bus.halted !== 1'b1) begin bad++; $display("FAIL jump_count got count=%0d halted=%b exp 4 1", bus.instr_count, bus.halted); end
  endtask

  task automatic test_step();
    rom_tgt = 12'h005;
    bus.load_pc = 1'b1;
    exp_q.push_back(12'h005);
    do_step();
    bus.load_pc = 1'b0; bus.inc_pc = 1'b1;
    exp_q.push_back(12'h006);
    bus.step_req = 1'b1; bus.run_req = 1'b1;
    tick();
    bus.step_req = 1'b0; bus.run_req = 1'b0;
    total++; if (bus.phase !== 1'b0 || bus.halted !== 1'b0 || bus.step_ack !== 1'b0) begin bad++; $display("FAIL step_fetch got phase=%b halted=%b ack=%b exp 0 0 0", bus.phase, bus.halted, bus.step_ack); end
    tick();
    total++; if (bus.phase !== 1'b1 || bus.step_ack !== 1'b0) begin bad++; $display("FAIL step_exec got phase=%b ack=%b exp 1 0", bus.phase, bus.step_ack); end
    tick();
    total++; if (bus.halted !== 1'b1 || bus.step_ack !== 1'b1) begin bad++; $display("FAIL step_done got halted=%b ack=%b exp 1 1", bus.halted, bus.step_ack); end
    tick();
    total++; if (bus.halted !== 1'b1 || bus.step_ack !== 1'b0 || bus.pc !== 12'h006) begin bad++; $display("FAIL step_after got halted=%b ack=%b pc=%h exp 1 0 006", bus.halted, bus.step_ack, bus.pc); end
  endtask

  task automatic test_breakpoint();
    mon_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    exp_q.delete();
    mon_en = 1'b1;
    bus.bp_en = 1'b1; bus.bp_addr = 12'h003;
    bus.inc_pc = 1'b1; bus.load_pc = 1'b0;
    exp_q.push_back(12'h001); exp_q.push_back(12'h002); exp_q.push_back(12'h003);
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    for (int i = 0; i < 20 && bus.halted !== 1'b1; i++) tick();
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL bp_timeout got halted=%b exp 1", bus.halted); end
    total++; if (bus.pc !== 12'h003 || bus.bp_hit !== 1'b1 || bus.instr_count !== 16'd3) begin bad++; $display("FAIL bp_stop got pc=%h bp=%b count=%0d exp 003 1 3", bus.pc, bus.bp_hit, bus.instr_count); end
    exp_q.push_back(12'h004);
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    total++; if (bus.bp_hit !== 1'b0 || bus.halted !== 1'b0) begin bad++; $display("FAIL bp_resume got bp=%b halted=%b exp 0 0", bus.bp_hit, bus.halted); end
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    tick();
    total++; if (bus.halted !== 1'b1 || bus.bp_hit !== 1'b0) begin bad++; $display("FAIL bp_past got halted=%b bp=%b exp 1 0", bus.halted, bus.bp_hit); end
    bus.bp_en = 1'b0;
  endtask

  task automatic test_flags();
    bus.inc_pc = 1'b1;
    bus.load_flags = 1'b1; bus.alu_carry = 1'b1; bus.alu_zero = 1'b0;
    exp_q.push_back(12'h005);
    do_step();
    total++; if (bus.c_flag !== 1'b1 || bus.z_flag !== 1'b0) begin bad++; $display("FAIL flags_load got c=%b z=%b exp 1 0", bus.c_flag, bus.z_flag); end
    bus.load_flags = 1'b0; bus.alu_carry = 1'b0; bus.alu_zero = 1'b1;
    exp_q.push_back(12'h006);
    do_step();
    total++; if (bus.c_flag !== 1'b1 || bus.z_flag !== 1'b0) begin bad++; $display("FAIL flags_hold got c=%b z=%b exp 1 0", bus.c_flag, bus.z_flag); end
    bus.load_flags = 1'b1;
    exp_q.push_back(12'h007);
    do_step();
    total++; if (bus.c_flag !== 1'b0 || bus.z_flag !== 1'b1) begin bad++; $display("FAIL flags_reload got c=%b z=%b exp 0 1", bus.c_flag, bus.z_flag); end
    bus.load_flags = 1'b0;
  endtask

  task automatic test_halt_req();
    bus.inc_pc = 1'b1;
    exp_q.push_back(12'h008); exp_q.push_back(12'h009); exp_q.push_back(12'h00A);
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++; if (bus.phase !== 1'b0 || bus.halted !== 1'b0 || bus.pc !== 12'h009) begin bad++; $display("FAIL halt_running got phase=%b halted=%b pc=%h exp 0 0 009", bus.phase, bus.halted, bus.pc); end
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    total++; if (bus.phase !== 1'b1) begin bad++; $display("FAIL halt_completes got phase=%b exp 1", bus.phase); end
    tick();
    total++; if (bus.halted !== 1'b1 || bus.instr_count !== 16'd10) begin bad++; $display("FAIL halt_stop got halted=%b count=%0d exp 1 10", bus.halted, bus.instr_count); end
    tick();
    total++; if (bus.halted !== 1'b1 || bus.pc !== 12'h00A) begin bad++; $display("FAIL halt_stays got halted=%b pc=%h exp 1 00a", bus.halted, bus.pc); end
  endtask

  task automatic test_reset_mid_exec();
    mon_en = 1'b0;
    bus.inc_pc = 1'b1;
    bus.load_flags = 1'b1; bus.alu_carry = 1'b1; bus.alu_zero = 1'b1;
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    tick();
    total++; if (bus.phase !== 1'b1) begin bad++; $display("FAIL rst_exec_reach got phase=%b exp 1", bus.phase); end
    reset = 1'b1;
    tick();
    total++; if (bus.pc !== 12'h000 || bus.halted !== 1'b1 || bus.phase !== 1'b0) begin bad++; $display("FAIL rst_exec_state got pc=%h halted=%b phase=%b exp 000 1 0", bus.pc, bus.halted, bus.phase); end
    total++; if (bus.c_flag !== 1'b0 || bus.z_flag !== 1'b0 || bus.instr_count !== 16'd0 || bus.step_ack !== 1'b0) begin bad++; $display("FAIL rst_exec_regs got c=%b z=%b count=%0d ack=%b exp 0 0 0 0", bus.c_flag, bus.z_flag, bus.instr_count, bus.step_ack); end
    reset = 1'b0;
    bus.load_flags = 1'b0;
    tick();
    total++; if (bus.halted !== 1'b1 || bus.pc !== 12'h000) begin bad++; $display("FAIL rst_exec_after got halted=%b pc=%h exp 1 000", bus.halted, bus.pc); end
    mon_en = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_run_basic();
    test_jump_wrap();
    test_step();
    test_breakpoint();
    test_flags();
    test_halt_req();
    test_reset_mid_exec();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
